// File: rtl/cfg_chain_loader_if.sv
// Configuration word stream from the host/config controller into the chain loader.
interface cfg_chain_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_chain_loader.sv
// Serialises 32-bit configuration words MSB-first onto a fabric row scan chain
// and folds the bits returned by the chain into a CRC-16 for readback.
//
// state     | meaning
// IDLE      | waiting for start; counters cleared
// WAIT_WORD | chain stalled, s_ready high until a word arrives
// SHIFT     | one chain bit per cycle from the shift register
// FINISH    | done pulse, back to IDLE
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  cfg_chain_loader_if.slave s_if,
  output logic              cfg_in,
  output logic              cfg_en,
  input  logic              cfg_ret,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rb_crc
);
  localparam int NWORDS = (CHAIN_LEN + 31) / 32;
  localparam int RBITS  = CHAIN_LEN - 32 * (NWORDS - 1);
  localparam int WW     = $clog2(NWORDS + 1);
  localparam logic [WW-1:0] NWORDS_W  = WW'(NWORDS);
  localparam logic [4:0]    LAST_BITS = 5'(RBITS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, FINISH} state_t;

  state_t         state_q;
  logic [31:0]    shift_q;
  logic [4:0]     bcnt_q;
  logic [WW-1:0]  wleft_q;
  logic           cfg_in_q, cfg_en_q, busy_q, done_q;
  logic [15:0]    crc_q;
  logic [15:0]    crc_d;
  logic           rdy, hs, crc_fb;

  always_comb begin
    rdy    = !abort && ((state_q == WAIT_WORD) ||
                        (state_q == SHIFT && bcnt_q == 5'd0 && wleft_q != '0));
    hs     = rdy && s_if.s_valid;
    crc_fb = crc_q[15] ^ cfg_ret;
    crc_d  = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      wleft_q  <= '0;
      cfg_in_q <= 1'b0;
      cfg_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      crc_q    <= 16'hFFFF;
    end else begin
      done_q <= 1'b0;
      // The chain shifts on every edge where cfg_en is high, including an abort edge.
      if (cfg_en_q) crc_q <= crc_d;

      if (abort && state_q != IDLE) begin
        state_q  <= IDLE;
        cfg_en_q <= 1'b0;
        cfg_in_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (hs) begin
        // First bit goes straight to cfg_in; the register holds the rest.
        state_q  <= SHIFT;
        cfg_in_q <= s_if.s_data[31];
        cfg_en_q <= 1'b1;
        shift_q  <= {s_if.s_data[30:0], 1'b0};
        bcnt_q   <= (wleft_q == WW'(1)) ? LAST_BITS : 5'd31;
        wleft_q  <= wleft_q - WW'(1);
      end else begin
        case (state_q)
          IDLE: begin
            bcnt_q  <= '0;
            wleft_q <= NWORDS_W;
            if (start) begin
              state_q <= WAIT_WORD;
              busy_q  <= 1'b1;
              crc_q   <= 16'hFFFF;
            end
          end
          WAIT_WORD: ;
          SHIFT: begin
            if (bcnt_q != 5'd0) begin
              bcnt_q   <= bcnt_q - 5'd1;
              cfg_in_q <= shift_q[31];
              shift_q  <= {shift_q[30:0], 1'b0};
            end else if (wleft_q == '0) begin
              state_q  <= FINISH;
              cfg_en_q <= 1'b0;
              cfg_in_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q  <= WAIT_WORD;
              cfg_en_q <= 1'b0;
              cfg_in_q <= 1'b0;
            end
          end
          FINISH:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign s_if.s_ready = rdy;
  assign cfg_in       = cfg_in_q;
  assign cfg_en       = cfg_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rb_crc       = crc_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomised bench for cfg_chain_loader: three builds (40, 32, 1 bits) each driving
// a scan-chain model, checked against a word/bit-level reference of the load.
`timescale 1ns/1ps
module tb_cfg_chain_loader;
  localparam int NI = 3;

  logic                   prog_clk = 1'b0;
  logic                   prog_rst_n;
  logic [NI-1:0]          start, abort, s_valid, s_ready;
  logic [NI-1:0][31:0]    s_data;
  logic [NI-1:0]          cfg_in, cfg_en, cfg_ret, busy, done;
  logic [NI-1:0][15:0]    rb_crc;

  logic [NI-1:0][39:0]    chain;
  logic [NI-1:0][39:0]    load_val;
  logic [NI-1:0]          load_req, mon_clr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_cnt[NI], first_en[NI], last_en[NI], done_cnt[NI], done_cyc[NI];
  logic busy_at_done[NI];
  bit obs_q[NI][$];

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader_if if0 ();
  cfg_chain_loader_if if1 ();
  cfg_chain_loader_if if2 ();
  assign if0.s_data = s_data[0]; assign if0.s_valid = s_valid[0]; assign s_ready[0] = if0.s_ready;
  assign if1.s_data = s_data[1]; assign if1.s_valid = s_valid[1]; assign s_ready[1] = if1.s_ready;
  assign if2.s_data = s_data[2]; assign if2.s_valid = s_valid[2]; assign s_ready[2] = if2.s_ready;

  cfg_chain_loader #(.CHAIN_LEN(40)) u_dut40 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start[0]), .abort(abort[0]),
    .s_if(if0), .cfg_in(cfg_in[0]), .cfg_en(cfg_en[0]), .cfg_ret(cfg_ret[0]),
    .busy(busy[0]), .done(done[0]), .rb_crc(rb_crc[0]));
  cfg_chain_loader #(.CHAIN_LEN(32)) u_dut32 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start[1]), .abort(abort[1]),
    .s_if(if1), .cfg_in(cfg_in[1]), .cfg_en(cfg_en[1]), .cfg_ret(cfg_ret[1]),
    .busy(busy[1]), .done(done[1]), .rb_crc(rb_crc[1]));
  cfg_chain_loader #(.CHAIN_LEN(1)) u_dut1 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start[2]), .abort(abort[2]),
    .s_if(if2), .cfg_in(cfg_in[2]), .cfg_en(cfg_en[2]), .cfg_ret(cfg_ret[2]),
    .busy(busy[2]), .done(done[2]), .rb_crc(rb_crc[2]));

  function automatic int len_of(input int k);
    return (k == 0) ? 40 : (k == 1) ? 32 : 1;
  endfunction

  // Chain model: cell 0 takes prog_in, cell len-1 drives prog_out.
  always @(posedge prog_clk)
    for (int k = 0; k < NI; k++)
      if (load_req[k]) chain[k] <= load_val[k];
      else if (cfg_en[k]) chain[k] <= {chain[k][38:0], cfg_in[k]};

  always_comb begin
    cfg_ret = '0;
    for (int k = 0; k < NI; k++) cfg_ret[k] = chain[k][len_of(k)-1];
  end

  always @(negedge prog_clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (mon_clr[k]) begin
        en_cnt[k] = 0; first_en[k] = 0; last_en[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
        busy_at_done[k] = 1'b0;
        obs_q[k].delete();
      end else begin
        if (cfg_en[k]) begin
          obs_q[k].push_back(cfg_in[k]);
          if (en_cnt[k] == 0) first_en[k] = cyc;
          last_en[k] = cyc;
          en_cnt[k]++;
        end
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          busy_at_done[k] = busy[k];
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/CCITT of the first m bits leaving a chain of len cells (cell len-1 first).
  function automatic logic [15:0] crc_ref(input logic [39:0] v, input int len, input int m);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    for (int i = len - 1; i >= len - m; i--) begin
      fb = v[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic run_load(input int k, input bit directed, input int dly_fix,
                          input int abort_at, input int start_at);
    int          len, nw, nb, dly, d0, wi, shifts, gap_sum, budget, start_cyc, rdy_seen;
    logic [31:0] w[2];
    logic [39:0] pre, mask, exp_vec, obs_vec;
    bit          hs, fin, first;

    len  = len_of(k);
    nw   = (len + 31) / 32;
    mask = (40'h1 << len) - 40'h1;
    if (len == 40) mask = '1;
    pre  = directed ? '1 : ({$urandom, $urandom} & mask);
    w[0] = directed ? 32'hA5A5A5A5 : $urandom;
    w[1] = directed ? 32'hFF000000 : $urandom;

    exp_vec = '0;
    for (int i = 0; i < nw; i++) begin
      nb = (i == nw - 1) ? len - 32 * (nw - 1) : 32;
      for (int b = 31; b >= 32 - nb; b--) exp_vec = {exp_vec[38:0], w[i][b]};
    end

    @(negedge prog_clk); #1;
    load_req[k] = 1'b1; load_val[k] = pre; mon_clr[k] = 1'b1;
    @(negedge prog_clk); #1;
    load_req[k] = 1'b0; mon_clr[k] = 1'b0;

    start[k] = 1'b1;
    start_cyc = cyc;
    @(negedge prog_clk); #1;
    start[k] = 1'b0;
    check_val("busy_after_start", busy[k], 1);

    wi = 0; shifts = 0; gap_sum = 0; budget = 0; fin = 0; first = 1;
    dly = (dly_fix >= 0) ? 0 : $urandom_range(0, 4);
    d0  = dly;
    while (!fin && budget < 400) begin
      if (cfg_en[k]) shifts++;
      abort[k]   = (abort_at != 0 && shifts == abort_at && cfg_en[k]);
      start[k]   = (start_at != 0 && shifts == start_at && cfg_en[k]);
      s_valid[k] = (wi < nw && dly == 0);
      s_data[k]  = (wi < nw) ? w[wi] : $urandom;
      #1;
      hs = s_valid[k] && s_ready[k];
      if (hs) begin
        wi++;
        if (wi < nw) begin
          dly = (dly_fix >= 0) ? dly_fix : $urandom_range(0, 6);
          gap_sum += dly;
        end
      end else if (s_ready[k] && !s_valid[k] && dly > 0) begin
        dly--;
      end
      if (abort[k] || done[k]) fin = 1;
      @(negedge prog_clk); #1;
      budget++;
    end
    abort[k] = 1'b0; start[k] = 1'b0; s_valid[k] = 1'b0;
    check_val("load_in_budget", budget < 400, 1);

    if (abort_at != 0) begin
      check_val("abort_cfg_en_off", cfg_en[k], 0);
      check_val("abort_busy_off", busy[k], 0);
      s_valid[k] = 1'b1;
      rdy_seen = 0;
      repeat (4) begin
        @(negedge prog_clk); #2;
        rdy_seen += int'(s_ready[k]);
      end
      s_valid[k] = 1'b0;
      check_val("abort_no_ready", rdy_seen, 0);
      check_val("abort_no_done", done_cnt[k], 0);
      check_val("abort_shift_cnt", en_cnt[k], abort_at);
      check_val("abort_crc_partial", rb_crc[k], crc_ref(pre, len, abort_at));
    end else begin
      repeat (4) @(negedge prog_clk);
      #1;
      obs_vec = '0;
      foreach (obs_q[k][i]) obs_vec = {obs_vec[38:0], obs_q[k][i]};
      check_val("shift_count", en_cnt[k], len);
      check_val("bit_sequence", obs_vec, exp_vec);
      check_val("first_en_latency", first_en[k], start_cyc + 2 + d0);
      check_val("en_span", last_en[k] - first_en[k] + 1, len + gap_sum);
      check_val("done_count", done_cnt[k], 1);
      check_val("done_after_last_en", done_cyc[k], last_en[k] + 1);
      check_val("busy_low_at_done", busy_at_done[k], 0);
      check_val("rb_crc", rb_crc[k], crc_ref(pre, len, len));
      check_val("chain_contents", chain[k] & mask, exp_vec);
      check_val("idle_ready_low", s_ready[k], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    start = '0; abort = '0; s_valid = '0; s_data = '0;
    load_req = '0; load_val = '0; mon_clr = '1;
    prog_rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("rst_cfg_en%0d", k), cfg_en[k], 0);
      check_val($sformatf("rst_cfg_in%0d", k), cfg_in[k], 0);
      check_val($sformatf("rst_s_ready%0d", k), s_ready[k], 0);
      check_val($sformatf("rst_busy%0d", k), busy[k], 0);
      check_val($sformatf("rst_done%0d", k), done[k], 0);
      check_val($sformatf("rst_crc%0d", k), rb_crc[k], 16'hFFFF);
    end
    @(negedge prog_clk); #1;
    prog_rst_n = 1'b1;
    mon_clr = '0;

    run_load(0, 1'b1, 0, 0, 0);
    run_load(0, 1'b1, 5, 0, 0);
    for (int r = 0; r < 6; r++) run_load(0, 1'b0, -1, 0, 0);
    run_load(0, 1'b0, -1, 10, 0);
    for (int r = 0; r < 3; r++) run_load(0, 1'b0, -1, $urandom_range(1, 40), 0);
    run_load(0, 1'b0, -1, 0, $urandom_range(1, 40));
    for (int r = 0; r < 3; r++) run_load(1, 1'b0, -1, 0, 0);
    run_load(1, 1'b0, -1, 0, $urandom_range(1, 32));
    for (int r = 0; r < 3; r++) run_load(2, 1'b0, -1, 0, 0);
    run_load(2, 1'b0, -1, 1, 0);

    @(negedge prog_clk); #1;
    start[0] = 1'b1;
    @(negedge prog_clk); #1;
    start[0] = 1'b0; s_valid[0] = 1'b1; s_data[0] = $urandom;
    repeat (8) @(negedge prog_clk);
    #1;
    check_val("arst_pre_en", cfg_en[0], 1);
    #2 prog_rst_n = 1'b0;
    #1;
    check_val("arst_cfg_en", cfg_en[0], 0);
    check_val("arst_cfg_in", cfg_in[0], 0);
    check_val("arst_busy", busy[0], 0);
    check_val("arst_s_ready", s_ready[0], 0);
    check_val("arst_done", done[0], 0);
    check_val("arst_crc", rb_crc[0], 16'hFFFF);
    s_valid[0] = 1'b0;
    @(negedge prog_clk); #1;
    prog_rst_n = 1'b1;
    repeat (2) @(negedge prog_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Bitstream loader that drives the configuration scan chain of a fabric row (the `prog_in` / `prog_en` / `prog_out` chain threaded through the CLB cells). It accepts 32-bit configuration words over a valid/ready stream and serialises them MSB-first onto the chain, shifting exactly `CHAIN_LEN` bits per load. It also captures the bits the chain shifts out, which are the previous configuration, into a CRC-16 for readback verification. It sits between the host/config controller and the first row's `prog_in`.

## Interface
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be ≥ 1.
- `prog_clk`, in, 1: programming clock; all logic on the rising edge.
- `prog_rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `abort`, in, 1: cancel the load in progress.
- `s_data`, in, 32: configuration word, bit 31 shifted first.
- `s_valid`, in, 1: `s_data` valid.
- `s_ready`, out, 1: loader accepts `s_data` this cycle.
- `cfg_in`, out, 1: serial data to the chain `prog_in`.
- `cfg_en`, out, 1: shift enable to the chain `prog_en`.
- `cfg_ret`, in, 1: chain `prog_out`, the returned bit.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse on successful completion.
- `rb_crc`, out, 16: CRC-16 of the returned bits; holds its value after `done`.

## Operation
- Derived values: NWORDS = ceil(CHAIN_LEN/32); the last word carries R = CHAIN_LEN − 32·(NWORDS−1) bits, taken from `s_data[31:32−R]`. Its low bits are ignored.
- State machine states:
  - IDLE
  - WAIT_WORD
  - SHIFT
  - FINISH
- IDLE:
  - `start` → WAIT_WORD.
  - Clears the word counter and the bit counter.
  - Loads `rb_crc` with 0xFFFF.
- WAIT_WORD:
  - `s_ready` = 1.
  - A handshake (`s_valid`·`s_ready`) loads the 32-bit shift register → SHIFT.
- SHIFT:
  - Each cycle `cfg_en` = 1 and `cfg_in` = shift_reg[31]; the register shifts left by 1.
  - Shifts 32 bits per word, or R bits for the final word.
  - On the last bit of a non-final word, `s_ready` = 1. If a handshake occurs, the next word loads and SHIFT continues with no gap; otherwise → WAIT_WORD.
  - After the last bit of the final word → FINISH.
- FINISH: `done` = 1 for one cycle → IDLE.
- Readback: on every rising edge where the registered `cfg_en` = 1, `rb_crc` ← CRC step(`rb_crc`, `cfg_ret`).
  - Polynomial 0x1021 (CCITT), MSB-first, no reflection, no final XOR.
  - The fabric shifts on the same edge, so the Nth update captures the Nth old bit.
- `start` while busy is ignored. `s_ready` = 0 outside WAIT_WORD and outside the last-bit SHIFT cycle.
- `abort` (any state other than IDLE):
  - → IDLE next cycle; `cfg_en` = 0 from that edge.
  - No `done`; `rb_crc` holds its partial value.
  - `abort` takes priority over a simultaneous handshake; the word is not consumed, so `s_ready` = 0 that cycle.
- Bits reach the chain far end first: the first bit shifted lands in the last cell.

## Timing
- Reset values:
  - `cfg_in` = 0, `cfg_en` = 0
  - `s_ready` = 0, `busy` = 0, `done` = 0
  - `rb_crc` = 0xFFFF
  - state = IDLE
- `cfg_in` and `cfg_en` are registered outputs with no combinational path from inputs. `s_ready` is decoded from state and bit count only, never from `s_valid`.
- Latency:
  - `start` sampled at edge T: WAIT_WORD and `busy` = 1 from T+1.
  - Handshake at edge H: first `cfg_en` = 1 cycle is H+1.
  - With `s_valid` held high, `cfg_en` is high for exactly CHAIN_LEN contiguous cycles.
  - `done` is high in the cycle immediately after the last `cfg_en`-high cycle; `busy` drops with `done`.
- Source stall: `cfg_en` = 0 during WAIT_WORD. The chain holds its state and no bits are lost.
- `cfg_en` high cycles per load = CHAIN_LEN exactly, for any stall pattern.
- Asynchronous reset mid-load forces all outputs to reset values immediately. The chain contents are then undefined and a full reload is required.
- CHAIN_LEN ≤ 32: single word, R = CHAIN_LEN.
- CHAIN_LEN multiple of 32: R = 32.

## Test plan
- CHAIN_LEN=40; words 0xA5A5A5A5 and 0xFF000000, `s_valid` always high, handshake at edge 1 → `cfg_en` high for cycles 2–41. The `cfg_in` sequence is 1010…0101 (32 bits) then 11111111. `done` pulses at cycle 42.
- CHAIN_LEN=40 with a 40-bit shift-register chain model preloaded with all-ones, looped to `cfg_ret` → `rb_crc` equals the golden CRC of 40 ones. Chain model contents afterwards equal the loaded pattern.
- Stall: `s_valid` for word 2 delayed 5 cycles → `cfg_en` = 0 for exactly those wait cycles. Total `cfg_en` high count = 40; bit sequence identical to the first test.
- `abort` asserted on the 10th shift cycle → `cfg_en` = 0 from the next cycle. No `done`, `busy` = 0, next `s_ready` only after a new `start`.
- `start` pulsed during SHIFT → ignored: exactly one `done` and exactly 40 shifts.
- CHAIN_LEN=32 and CHAIN_LEN=1 builds:
  - one word accepted;
  - 32 and 1 `cfg_en` cycles respectively;
  - CHAIN_LEN=1 shifts only `s_data[31]`.
